mult_sched: RTL and testbench
=============================

Name: mult_sched

Overview:
Controller that sequences the shared sequential multiplier on behalf of the 3-stage pipeline's execute stage.
- Launches a multiply on MULT (opcode 1111), counts the multiplier latency and captures the 32-bit product into LO/HI holding registers.
- Serves MFLO (1101) and MFHI (1110) reads.
- Raises a stall to the pipeline while a request cannot yet be served.
- Sits between the execute stage and the mult instance, replacing direct wiring of start/operands/result.

Parameters:
MULT_LAT, 16, multiplier cycles from ini pulse to valid product; legal range 1..255
CNT_W, 8, width of latency down-counter; must hold MULT_LAT-1

Ports:
clk  in  1  pipeline clock (CLK[25] domain)
reset  in  1  synchronous, active-low reset
req_start  in  1  execute stage requests a multiply; held while stall=1
req_a  in  16  operand A, sampled on accepted req_start
req_b  in  16  operand B, sampled on accepted req_start
req_rd_lo  in  1  MFLO request; held while stall=1
req_rd_hi  in  1  MFHI request; held while stall=1
flush  in  1  branch/jump flush; aborts an in-flight multiply
stall  out  1  combinational; pipeline must freeze D/E/M registers
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  16  LO or HI value returned
mult_ini  out  1  start pulse to multiplier
mult_a  out  16  registered operand A to multiplier
mult_b  out  16  registered operand B to multiplier
mult_res  in  32  multiplier product
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when product captured
lo  out  16  LO holding register
hi  out  16  HI holding register

Behaviour:
- All flops update on posedge clk.
- reset=0 (synchronous, highest priority):
  - state=IDLE, cnt=0.
  - lo, hi, mult_a, mult_b, rd_data = 0.
  - mult_ini, rd_valid, done = 0.
- States: IDLE, LAUNCH, RUN.
- IDLE:
  - req_start=1: latch req_a/req_b into mult_a/mult_b, mult_ini=1 next cycle, go to LAUNCH.
  - No request: remain IDLE.
- LAUNCH (1 cycle):
  - mult_ini=1, cnt loaded with MULT_LAT-1, go to RUN.
- RUN:
  - mult_ini=0.
  - cnt!=0: decrement.
  - cnt==0: {hi,lo} <= mult_res, done=1 for that following cycle, go to IDLE.
  - Total latency: accepted req_start at cycle T gives done at T+MULT_LAT+2.
- stall = busy & (req_start | req_rd_lo | req_rd_hi); stall=0 in IDLE.
- Reads in IDLE:
  - rd_data <= lo (req_rd_lo) or hi (req_rd_hi); rd_valid=1 next cycle for exactly one cycle.
  - Both asserted: lo wins, hi ignored (protocol violation, no error flag).
- Read stalled while busy: held by requester; served in the first IDLE cycle, returning the newly captured value.
- req_start and req_rd_* together in IDLE: both accepted, no stall; read returns the pre-multiply lo/hi.
- req_start while busy: stalled; launched in the first IDLE cycle. Back-to-back multiplies therefore have no overlap.
- flush=1 (below reset, above everything else):
  - From LAUNCH/RUN: go to IDLE, mult_ini=0, lo/hi unchanged, done=0.
  - In IDLE: same-cycle req_start and reads are dropped.
- mult_res is sampled only at the RUN, cnt==0 edge; other values are ignored.
- MULT_LAT=1: RUN lasts a single cycle (cnt loaded 0).
- Reset mid-RUN: full reset, lo/hi cleared, no done pulse.

Test Plan:
- Reset then idle, 5 cycles → all outputs 0, stall=0, busy=0.
- MULT_LAT=16, req_start at T with a=0x0003, b=0x0005, mult_res model=a*b → mult_ini high at T+1 only, done at T+18, lo=0x000F, hi=0x0000; busy T+1..T+17.
- a=0xFFFF, b=0xFFFF, then req_rd_hi held from T+2 → stall=1 until done, rd_valid one cycle later with rd_data=0xFFFE; subsequent req_rd_lo → 0x0001.
- Completed product lo=0x000F, then in IDLE req_start (a=2, b=4) with req_rd_lo same cycle → no stall, rd_data=0x000F; after done lo=0x0008.
- flush at RUN cycle 5 of a 0x0010*0x0010 multiply → IDLE next cycle, done never pulses, lo/hi retain 0x0008/0x0000.
- reset deasserted mid-RUN, then second req_start held during busy → held start stalls, launches on first IDLE cycle, second done exactly MULT_LAT+2 cycles after launch acceptance.

Source files
------------

// File: rtl/mult_sched_if.sv
// mult_sched_if: execute-stage <-> multiply scheduler request/response bundle.
//   req_start        multiply request, held by the pipeline while stall=1
//   req_a/req_b      16-bit operands, sampled when req_start is accepted
//   req_rd_lo/hi     MFLO / MFHI requests, held while stall=1
//   flush            branch/jump flush, aborts an in-flight multiply
//   stall            scheduler -> pipeline freeze (combinational)
//   rd_valid/rd_data one-cycle read response carrying LO or HI
// master = pipeline side, slave = scheduler side.
interface mult_sched_if;
  logic        req_start;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_rd_lo;
  logic        req_rd_hi;
  logic        flush;
  logic        stall;
  logic        rd_valid;
  logic [15:0] rd_data;

  modport master (
    output req_start, req_a, req_b, req_rd_lo, req_rd_hi, flush,
    input  stall, rd_valid, rd_data
  );

  modport slave (
    input  req_start, req_a, req_b, req_rd_lo, req_rd_hi, flush,
    output stall, rd_valid, rd_data
  );
endinterface

// File: rtl/mult_sched.sv
// mult_sched: sequences a shared sequential multiplier for the execute stage.
// Launches a multiply on request, counts MULT_LAT cycles, captures the 32-bit
// product into HI/LO and serves MFLO/MFHI reads, stalling the pipeline while
// a request cannot be served.
// Ports:
//   clk       pipeline clock
//   reset     synchronous, active-low reset
//   pipe      execute-stage request/response bundle (slave side)
//   mult_ini  start pulse to the multiplier (high during LAUNCH)
//   mult_a/b  registered operands to the multiplier
//   mult_res  multiplier product, sampled once at the end of RUN
//   busy      state != IDLE
//   done      one-cycle pulse after the product is captured
//   lo/hi     product holding registers
module mult_sched #(
  parameter int unsigned MULT_LAT = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic          clk,
  input  logic          reset,
  mult_sched_if.slave   pipe,
  output logic          mult_ini,
  output logic [15:0]   mult_a,
  output logic [15:0]   mult_b,
  input  logic [31:0]   mult_res,
  output logic          busy,
  output logic          done,
  output logic [15:0]   lo,
  output logic [15:0]   hi
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        lo_q, lo_d;
  logic [15:0]        hi_q, hi_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic               ini_q, ini_d;
  logic               done_q, done_d;
  logic               rdv_q, rdv_d;
  logic [15:0]        rdd_q, rdd_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ini_q   <= 1'b0;
      done_q  <= 1'b0;
      rdv_q   <= 1'b0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ini_q   <= ini_d;
      done_q  <= done_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    a_d     = a_q;
    b_d     = b_q;
    ini_d   = 1'b0;
    done_d  = 1'b0;
    rdv_d   = 1'b0;
    rdd_d   = rdd_q;

    unique case (state_q)
      S_IDLE: begin
        // A start and a read in the same IDLE cycle are both accepted; the
        // read sees the pre-multiply LO/HI. Flush drops both.
        if (!pipe.flush) begin
          if (pipe.req_start) begin
            a_d     = pipe.req_a;
            b_d     = pipe.req_b;
            ini_d   = 1'b1;
            state_d = S_LAUNCH;
          end
          if (pipe.req_rd_lo) begin
            rdd_d = lo_q;
            rdv_d = 1'b1;
          end else if (pipe.req_rd_hi) begin
            rdd_d = hi_q;
            rdv_d = 1'b1;
          end
        end
      end

      S_LAUNCH: begin
        if (pipe.flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CNT_W'(MULT_LAT - 1);
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (pipe.flush) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          {hi_d, lo_d} = mult_res;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign pipe.stall    = busy & (pipe.req_start | pipe.req_rd_lo | pipe.req_rd_hi);
  assign pipe.rd_valid = rdv_q;
  assign pipe.rd_data  = rdd_q;
  assign mult_ini      = ini_q;
  assign mult_a        = a_q;
  assign mult_b        = b_q;
  assign done          = done_q;
  assign lo            = lo_q;
  assign hi            = hi_q;

endmodule

// File: tb/tb_mult_sched.sv
module tb_mult_sched;
  logic        clk;
  logic        reset;
  logic        mult_ini,  mult_ini1;
  logic [15:0] mult_a,    mult_a1;
  logic [15:0] mult_b,    mult_b1;
  logic [31:0] mult_res,  mult_res1;
  logic        busy,      busy1;
  logic        done,      done1;
  logic [15:0] lo,        lo1;
  logic [15:0] hi,        hi1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mult_sched_if pif ();
  mult_sched_if pif1 ();

  // Multiplier model: product of the registered operands.
  assign mult_res  = {16'h0, mult_a}  * {16'h0, mult_b};
  assign mult_res1 = {16'h0, mult_a1} * {16'h0, mult_b1};

  mult_sched #(.MULT_LAT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .pipe(pif.slave),
    .mult_ini(mult_ini), .mult_a(mult_a), .mult_b(mult_b), .mult_res(mult_res),
    .busy(busy), .done(done), .lo(lo), .hi(hi)
  );

  mult_sched #(.MULT_LAT(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .pipe(pif1.slave),
    .mult_ini(mult_ini1), .mult_a(mult_a1), .mult_b(mult_b1), .mult_res(mult_res1),
    .busy(busy1), .done(done1), .lo(lo1), .hi(hi1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rdlo;
    logic        rdhi;
    logic        fl;
    logic        exp_v;
    logic [15:0] exp_d;
    logic        exp_busy;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic [15:0] a, input logic [15:0] b,
                        input logic rl, input logic rh, input logic fl);
    pif.req_start = st;
    pif.req_a     = a;
    pif.req_b     = b;
    pif.req_rd_lo = rl;
    pif.req_rd_hi = rh;
    pif.flush     = fl;
  endtask

  // Full multiply from an IDLE cycle T, checking cycle-accurate timing up to done.
  task automatic do_mult(input logic [15:0] a, input logic [15:0] b, input logic rdlo,
                         input logic [15:0] exp_rd);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    set_in(1'b1, a, b, rdlo, 1'b0, 1'b0);
    #1;
    chk("start_stall", {31'h0, pif.stall}, 32'h0);
    step();
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    if (rdlo) begin
      chk("same_cycle_rd_valid", {31'h0, pif.rd_valid}, 32'h1);
      chk("same_cycle_rd_data", {16'h0, pif.rd_data}, {16'h0, exp_rd});
    end
    for (int k = 1; k <= 18; k++) begin
      chk($sformatf("mult_ini_k%0d", k), {31'h0, mult_ini}, {31'h0, (k == 1)});
      chk($sformatf("busy_k%0d", k), {31'h0, busy}, {31'h0, (k <= 17)});
      chk($sformatf("done_k%0d", k), {31'h0, done}, {31'h0, (k == 18)});
      if (k != 18) step();
    end
    chk("lo_after_done", {16'h0, lo}, {16'h0, p[15:0]});
    chk("hi_after_done", {16'h0, hi}, {16'h0, p[31:16]});
    step();
    chk("done_pulse_end", {31'h0, done}, 32'h0);
  endtask

  initial begin
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    pif1.req_start = 1'b0; pif1.req_a = '0; pif1.req_b = '0;
    pif1.req_rd_lo = 1'b0; pif1.req_rd_hi = 1'b0; pif1.flush = 1'b0;
    reset = 1'b0;
    // After the FFFF*FFFF test: lo=0x0001, hi=0xFFFE.
    //          st    rdlo  rdhi  fl    v     data      busy
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0};

    repeat (3) step();
    reset = 1'b1;
    repeat (5) step();
    chk("rst_stall", {31'h0, pif.stall}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_rd_valid", {31'h0, pif.rd_valid}, 32'h0);
    chk("rst_rd_data", {16'h0, pif.rd_data}, 32'h0);
    chk("rst_mult_ini", {31'h0, mult_ini}, 32'h0);
    chk("rst_mult_ab", {mult_a, mult_b}, 32'h0);
    chk("rst_lohi", {hi, lo}, 32'h0);

    // 3*5
    do_mult(16'h0003, 16'h0005, 1'b0, 16'h0);
    // 2*4 with MFLO in the same IDLE cycle: read returns old LO=0x000F
    do_mult(16'h0002, 16'h0004, 1'b1, 16'h000F);

    // Flush during RUN cycle 5 of 0x10*0x10
    set_in(1'b1, 16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    chk("pre_flush_busy", {31'h0, busy}, 32'h1);
    pif.flush = 1'b1;
    step();
    pif.flush = 1'b0;
    chk("flush_busy", {31'h0, busy}, 32'h0);
    for (int k = 0; k < 20; k++) begin
      chk("flush_no_done", {31'h0, done}, 32'h0);
      step();
    end
    chk("flush_lo", {16'h0, lo}, 32'h0008);
    chk("flush_hi", {16'h0, hi}, 32'h0000);

    // FFFF*FFFF with MFHI held from T+2
    set_in(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    step();
    pif.req_rd_hi = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      #1;
      chk($sformatf("rdhi_stall_k%0d", k), {31'h0, pif.stall}, 32'h1);
      chk($sformatf("rdhi_novalid_k%0d", k), {31'h0, pif.rd_valid}, 32'h0);
      step();
    end
    chk("ffff_done", {31'h0, done}, 32'h1);
    chk("ffff_stall_idle", {31'h0, pif.stall}, 32'h0);
    chk("ffff_hi", {16'h0, hi}, 32'hFFFE);
    step();
    pif.req_rd_hi = 1'b0;
    chk("rdhi_valid", {31'h0, pif.rd_valid}, 32'h1);
    chk("rdhi_data", {16'h0, pif.rd_data}, 32'hFFFE);
    step();
    chk("rdhi_valid_pulse", {31'h0, pif.rd_valid}, 32'h0);

    // IDLE read / flush table
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].st, 16'h0011, 16'h0022, tbl[i].rdlo, tbl[i].rdhi, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d_stall", i), {31'h0, pif.stall}, 32'h0);
      step();
      set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_valid", i), {31'h0, pif.rd_valid}, {31'h0, tbl[i].exp_v});
      chk($sformatf("tbl%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].exp_busy});
      if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), {16'h0, pif.rd_data}, {16'h0, tbl[i].exp_d});
    end

    // Reset mid-RUN
    set_in(1'b1, 16'h0007, 16'h0009, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_lohi", {hi, lo}, 32'h0);
    chk("midrst_ini", {31'h0, mult_ini}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);

    // Second start held while busy launches on the first IDLE cycle
    for (int k = 0; k <= 37; k++) begin
      chk($sformatf("b2b_ini_k%0d", k), {31'h0, mult_ini}, {31'h0, (k == 1 || k == 19)});
      chk($sformatf("b2b_busy_k%0d", k), {31'h0, busy},
          {31'h0, ((k >= 1 && k <= 17) || (k >= 19 && k <= 35))});
      chk($sformatf("b2b_done_k%0d", k), {31'h0, done}, {31'h0, (k == 18 || k == 36)});
      if (k == 18) chk("b2b_lo1", {16'h0, lo}, 32'h0009);
      if (k == 36) chk("b2b_lo2", {16'h0, lo}, 32'h0014);
      if (k == 0) set_in(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);
      else if (k >= 3 && k <= 18) set_in(1'b1, 16'h0004, 16'h0005, 1'b0, 1'b0, 1'b0);
      else set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      #1;
      if (k >= 3 && k <= 18) chk($sformatf("b2b_stall_k%0d", k), {31'h0, pif.stall}, {31'h0, (k < 18)});
      step();
    end
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

    // MULT_LAT=1: done at T+3
    pif1.req_start = 1'b1; pif1.req_a = 16'h0100; pif1.req_b = 16'h0300;
    step();
    pif1.req_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("lat1_ini_k%0d", k), {31'h0, mult_ini1}, {31'h0, (k == 1)});
      chk($sformatf("lat1_busy_k%0d", k), {31'h0, busy1}, {31'h0, (k <= 2)});
      chk($sformatf("lat1_done_k%0d", k), {31'h0, done1}, {31'h0, (k == 3)});
      if (k != 3) step();
    end
    chk("lat1_lohi", {hi1, lo1}, 32'h0003_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
